// File: rtl/csr_defs.sv
// Shared CSR addresses, field positions and exception codes for csr_file_v2.
package csr_defs;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int CRMD_PLV_LSB  = 0;
  localparam int CRMD_PLV_MSB  = 1;
  localparam int CRMD_IE       = 2;
  localparam int CRMD_DA       = 3;
  localparam int PRMD_PPLV_LSB = 0;
  localparam int PRMD_PPLV_MSB = 1;
  localparam int PRMD_PIE      = 2;
  localparam int ESTAT_IS10    = 10;
  localparam int ESTAT_TI      = 11;
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int TICLR_CLR     = 0;
  localparam int EENTRY_VA_LSB = 6;

  // LIE bit 10 has no interrupt source behind it
  localparam logic [12:0] ECFG_LIE_MASK = 13'h1bff;

  localparam logic [5:0] ECODE_ADE     = 6'h08;
  localparam logic [5:0] ECODE_ALE     = 6'h09;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

  function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old_val);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable timer: owns TCFG, the down-counter and the timer interrupt flag (ESTAT.IS[11]).
module csr_timer
  import csr_defs::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tcfg_we,
  input  logic [TIMER_W-1:0] tcfg_next,
  input  logic               ticlr_clr,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] timer_cnt,
  output logic               ti_flag
);

  logic [TIMER_W-1:0] load_next;
  logic [TIMER_W-1:0] load_cur;
  logic               hit_zero;

  assign load_next = {tcfg_next[TIMER_W-1:2], 2'b00};
  assign load_cur  = {tcfg[TIMER_W-1:2], 2'b00};
  assign hit_zero  = tcfg[TCFG_EN] && (timer_cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcfg      <= '0;
      timer_cnt <= '1;
      ti_flag   <= 1'b0;
    end else begin
      if (tcfg_we) tcfg <= tcfg_next;

      // all-ones is the parked state of an expired one-shot timer
      if (tcfg_we) begin
        if (tcfg_next[TCFG_EN]) timer_cnt <= load_next;
      end else if (tcfg[TCFG_EN] && (timer_cnt != '1)) begin
        if ((timer_cnt == '0) && tcfg[TCFG_PERIODIC]) timer_cnt <= load_cur;
        else                                          timer_cnt <= timer_cnt - TIMER_W'(1);
      end

      if (hit_zero)       ti_flag <= 1'b1;
      else if (ticlr_clr) ti_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/csr_file_v2.sv
// LoongArch CSR file: combinational read, posedge write, exception/ertn state and timer.
module csr_file_v2
  import csr_defs::*;
#(
  parameter int          SAVE_NUM  = 4,
  parameter int          TIMER_W   = 32,
  parameter int          HW_INT_W  = 8,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                csr_re,
  input  logic [13:0]         csr_num,
  output logic [31:0]         csr_rvalue,
  input  logic                csr_we,
  input  logic [31:0]         csr_wmask,
  input  logic [31:0]         csr_wvalue,
  input  logic                wb_ex,
  input  logic [5:0]          wb_ecode,
  input  logic [8:0]          wb_esubcode,
  input  logic [31:0]         wb_pc,
  input  logic [31:0]         wb_vaddr,
  input  logic                eret_flush,
  input  logic [HW_INT_W-1:0] hw_int_in,
  input  logic                ipi_int_in,
  output logic                has_int,
  output logic [31:0]         ex_entry,
  output logic [31:0]         era_out
);

  logic [1:0]  crmd_plv, prmd_pplv, estat_sw;
  logic        crmd_ie, prmd_pie, estat_ipi, ti_flag;
  logic [12:0] ecfg_lie;
  logic [7:0]  estat_hw, hw_pad;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esub;
  logic [31:0] era, badv, tid;
  logic [31:6] eentry;
  logic [31:0] save_q [SAVE_NUM];
  logic [31:0] crmd_r, prmd_r, estat_r, rd_raw, wnew;
  logic [TIMER_W-1:0] tcfg, timer_cnt;
  logic        wr_ok;

  assign wr_ok    = csr_we && !wb_ex && !eret_flush;
  assign ex_entry = {eentry, 6'b0};
  assign era_out  = era;

  always_comb begin
    hw_pad = '0;
    hw_pad[HW_INT_W-1:0] = hw_int_in;
  end

  always_comb begin
    crmd_r = '0;
    crmd_r[CRMD_DA] = 1'b1;
    crmd_r[CRMD_IE] = crmd_ie;
    crmd_r[CRMD_PLV_MSB:CRMD_PLV_LSB] = crmd_plv;
    prmd_r = '0;
    prmd_r[PRMD_PIE] = prmd_pie;
    prmd_r[PRMD_PPLV_MSB:PRMD_PPLV_LSB] = prmd_pplv;
    estat_r = '0;
    estat_r[1:0]        = estat_sw;
    estat_r[9:2]        = estat_hw;
    estat_r[ESTAT_IS10] = 1'b0;
    estat_r[ESTAT_TI]   = ti_flag;
    estat_r[12]         = estat_ipi;
    estat_r[21:16]      = estat_ecode;
    estat_r[30:22]      = estat_esub;
  end

  // rd_raw is also the old value of the write target, since read and write share csr_num
  always_comb begin
    rd_raw = '0;
    case (csr_num)
      CSR_CRMD:   rd_raw = crmd_r;
      CSR_PRMD:   rd_raw = prmd_r;
      CSR_ECFG:   rd_raw = {19'b0, ecfg_lie};
      CSR_ESTAT:  rd_raw = estat_r;
      CSR_ERA:    rd_raw = era;
      CSR_BADV:   rd_raw = badv;
      CSR_EENTRY: rd_raw = ex_entry;
      CSR_TID:    rd_raw = tid;
      CSR_TCFG:   rd_raw = 32'(tcfg);
      CSR_TVAL:   rd_raw = 32'(timer_cnt);
      default:    rd_raw = '0;
    endcase
    for (int i = 0; i < SAVE_NUM; i++)
      if (csr_num == CSR_SAVE0 + 14'(i)) rd_raw = save_q[i];
  end

  assign csr_rvalue = csr_re ? rd_raw : 32'h0;
  assign wnew       = csr_merge(rd_raw, csr_wmask, csr_wvalue);

  csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .tcfg_we   (wr_ok && (csr_num == CSR_TCFG)),
    .tcfg_next (wnew[TIMER_W-1:0]),
    .ticlr_clr (wr_ok && (csr_num == CSR_TICLR) && wnew[TICLR_CLR]),
    .tcfg      (tcfg),
    .timer_cnt (timer_cnt),
    .ti_flag   (ti_flag)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      crmd_plv    <= '0;
      crmd_ie     <= 1'b0;
      prmd_pplv   <= '0;
      prmd_pie    <= 1'b0;
      ecfg_lie    <= '0;
      estat_sw    <= '0;
      estat_hw    <= '0;
      estat_ipi   <= 1'b0;
      estat_ecode <= '0;
      estat_esub  <= '0;
      era         <= '0;
      badv        <= '0;
      eentry      <= '0;
      tid         <= TID_RESET;
      has_int     <= 1'b0;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
    end else begin
      estat_hw  <= hw_pad;
      estat_ipi <= ipi_int_in;
      has_int   <= crmd_ie && |(estat_r[12:0] & ecfg_lie);
      if (wb_ex) begin
        prmd_pplv   <= crmd_plv;
        prmd_pie    <= crmd_ie;
        crmd_plv    <= '0;
        crmd_ie     <= 1'b0;
        estat_ecode <= wb_ecode;
        estat_esub  <= wb_esubcode;
        era         <= wb_pc;
        if (wb_ecode == ECODE_ADE && wb_esubcode == ESUBCODE_ADEF)
          badv <= wb_pc;
        else if ((wb_ecode == ECODE_ADE && wb_esubcode == ESUBCODE_ADEM) || wb_ecode == ECODE_ALE)
          badv <= wb_vaddr;
      end else if (eret_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (csr_we) begin
        case (csr_num)
          CSR_CRMD: begin
            crmd_plv <= wnew[CRMD_PLV_MSB:CRMD_PLV_LSB];
            crmd_ie  <= wnew[CRMD_IE];
          end
          CSR_PRMD: begin
            prmd_pplv <= wnew[PRMD_PPLV_MSB:PRMD_PPLV_LSB];
            prmd_pie  <= wnew[PRMD_PIE];
          end
          CSR_ECFG:   ecfg_lie <= wnew[12:0] & ECFG_LIE_MASK;
          CSR_ESTAT:  estat_sw <= wnew[1:0];
          CSR_ERA:    era      <= wnew;
          CSR_BADV:   badv     <= wnew;
          CSR_EENTRY: eentry   <= wnew[31:EENTRY_VA_LSB];
          CSR_TID:    tid      <= wnew;
          default: ;
        endcase
        for (int i = 0; i < SAVE_NUM; i++)
          if (csr_num == CSR_SAVE0 + 14'(i)) save_q[i] <= wnew;
      end
    end
  end

endmodule

// File: tb/tb_csr_file_v2.sv
// Directed bench for csr_file_v2 (TIMER_W=8) with a queue scoreboard and immediate assertions.
module tb_csr_file_v2;

  localparam int          TW   = 8;
  localparam logic [31:0] TIDR = 32'h1234_5678;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        csr_re = 1'b0;
  logic [13:0] csr_num = '0;
  logic [31:0] csr_rvalue;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wmask = '0;
  logic [31:0] csr_wvalue = '0;
  logic        wb_ex = 1'b0;
  logic [5:0]  wb_ecode = '0;
  logic [8:0]  wb_esubcode = '0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_vaddr = '0;
  logic        eret_flush = 1'b0;
  logic [7:0]  hw_int_in = '0;
  logic        ipi_int_in = 1'b0;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] era_out;

  always #5 clock = ~clock;

  csr_file_v2 #(.SAVE_NUM(4), .TIMER_W(TW), .HW_INT_W(8), .TID_RESET(TIDR)) dut (
    .clock(clock), .reset(reset), .csr_re(csr_re), .csr_num(csr_num),
    .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .eret_flush(eret_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .has_int(has_int), .ex_entry(ex_entry), .era_out(era_out)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push_exp(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %h required an expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rdm(input logic [13:0] num, input logic [31:0] mask,
                     input logic [31:0] exp, input string tag);
    csr_num = num;
    csr_re  = 1'b1;
    push_exp(tag, exp & mask);
    #1;
    pop_check(csr_rvalue & mask);
    csr_re = 1'b0;
  endtask

  task automatic rd(input logic [13:0] num, input logic [31:0] exp, input string tag);
    rdm(num, 32'hffff_ffff, exp, tag);
  endtask

  task automatic chk(input string tag, input logic [31:0] exp, input logic [31:0] obs);
    push_exp(tag, exp);
    pop_check(obs);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_num    = num;
    csr_wmask  = mask;
    csr_wvalue = val;
    csr_we     = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    tick();

    // reset state
    rd(14'h000, 32'h8, "crmd_reset");
    rd(14'h040, TIDR, "tid_reset");
    rd(14'h099, 32'h0, "unimpl_read");
    rd(14'h042, 32'hff, "tval_reset");
    chk("has_int_reset", 32'h0, {31'b0, has_int});
    csr_re = 1'b0; csr_num = 14'h000;
    push_exp("rvalue_re_low", 32'h0);
    #1 pop_check(csr_rvalue);

    // exception entry and return
    wr(14'h000, 32'hffff_ffff, 32'h7);
    rd(14'h000, 32'hf, "crmd_written");
    wb_ex = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h0;
    wb_pc = 32'h1c00_0100; wb_vaddr = 32'h0000_dead;
    tick();
    wb_ex = 1'b0;
    rd(14'h000, 32'h8, "crmd_after_ex");
    rd(14'h001, 32'h7, "prmd_after_ex");
    rd(14'h006, 32'h1c00_0100, "era_after_ex");
    rd(14'h007, 32'h1c00_0100, "badv_adef");
    rd(14'h005, 32'h0008_0000, "estat_after_ex");
    eret_flush = 1'b1;
    tick();
    eret_flush = 1'b0;
    rd(14'h000, 32'hf, "crmd_after_ertn");

    // exception beats ertn and a same-cycle CSR write
    wb_ex = 1'b1; eret_flush = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0;
    wb_pc = 32'h1c00_0200; wb_vaddr = 32'h0000_abcd;
    csr_num = 14'h006; csr_wmask = 32'hffff_ffff; csr_wvalue = 32'h5555; csr_we = 1'b1;
    tick();
    wb_ex = 1'b0; eret_flush = 1'b0; csr_we = 1'b0;
    rd(14'h006, 32'h1c00_0200, "era_ex_wins");
    rd(14'h007, 32'h0000_abcd, "badv_ale");
    rd(14'h000, 32'h8, "crmd_ex_wins");
    chk("era_out", 32'h1c00_0200, era_out);

    // masked writes, reserved bits, read-before-write, SAVE bank
    wr(14'h006, 32'h0000_ffff, 32'h1234_5555);
    rd(14'h006, 32'h1c00_5555, "era_masked");
    wr(14'h00c, 32'hffff_ffff, 32'hffff_ffff);
    rd(14'h00c, 32'hffff_ffc0, "eentry_read");
    chk("ex_entry", 32'hffff_ffc0, ex_entry);
    wr(14'h004, 32'hffff_ffff, 32'hffff_ffff);
    rd(14'h004, 32'h1bff, "ecfg_lie10_zero");
    wr(14'h004, 32'hffff_ffff, 32'h0);
    wr(14'h005, 32'hffff_ffff, 32'hffff_ffff);
    rd(14'h005, 32'h0009_0003, "estat_sw_only");
    wr(14'h005, 32'h3, 32'h0);
    csr_num = 14'h031; csr_wmask = 32'hffff_ffff; csr_wvalue = 32'ha5a5_a5a5;
    csr_we = 1'b1; csr_re = 1'b1;
    push_exp("save1_pre_write", 32'h0);
    #1 pop_check(csr_rvalue);
    tick();
    csr_we = 1'b0; csr_re = 1'b0;
    rd(14'h031, 32'ha5a5_a5a5, "save1_written");
    wr(14'h034, 32'hffff_ffff, 32'h1111_1111);
    rd(14'h034, 32'h0, "save_out_of_range");
    wr(14'h099, 32'hffff_ffff, 32'h2222_2222);
    rd(14'h099, 32'h0, "unimpl_write_ignored");

    // hardware and IPI interrupt sampling latency
    hw_int_in = 8'h05; ipi_int_in = 1'b1;
    rdm(14'h005, 32'h1ffc, 32'h0, "is_hw_before_edge");
    tick();
    rdm(14'h005, 32'h1ffc, 32'h1014, "is_hw_sampled");
    hw_int_in = 8'h00; ipi_int_in = 1'b0;
    tick();
    rdm(14'h005, 32'h1ffc, 32'h0, "is_hw_cleared");

    // periodic timer: INITVAL=2 -> count 8..0, flag on zero, reload
    wr(14'h041, 32'hffff_ffff, 32'h0b);
    rd(14'h042, 32'h8, "tval_loaded");
    rd(14'h041, 32'h0b, "tcfg_read");
    for (int k = 1; k <= 8; k++) begin
      tick();
      rd(14'h042, 32'(8 - k), "tval_periodic");
      rdm(14'h005, 32'h800, 32'h0, "ti_not_yet");
    end
    wr(14'h044, 32'h1, 32'h1);
    rd(14'h042, 32'h8, "tval_reload");
    rdm(14'h005, 32'h800, 32'h800, "ti_set_beats_clr");
    rd(14'h044, 32'h0, "ticlr_reads_zero");

    // interrupt request path
    wr(14'h004, 32'hffff_ffff, 32'h800);
    rd(14'h004, 32'h800, "ecfg_lie11");
    wr(14'h000, 32'hffff_ffff, 32'h4);
    chk("has_int_latency", 32'h0, {31'b0, has_int});
    tick();
    chk("has_int_set", 32'h1, {31'b0, has_int});
    wr(14'h044, 32'h1, 32'h1);
    chk("has_int_hold", 32'h1, {31'b0, has_int});
    rdm(14'h005, 32'h800, 32'h0, "ti_cleared");
    tick();
    chk("has_int_clear", 32'h0, {31'b0, has_int});
    rd(14'h042, 32'h3, "tval_running");

    // EN=0 write freezes the count
    wr(14'h041, 32'hffff_ffff, 32'h0a);
    rd(14'h042, 32'h3, "tval_frozen");
    tick();
    rd(14'h042, 32'h3, "tval_still_frozen");

    // one-shot: INITVAL=1 -> 4..0, wrap to all-ones and hold
    wr(14'h041, 32'hffff_ffff, 32'h05);
    rd(14'h042, 32'h4, "tval_oneshot_load");
    for (int k = 1; k <= 4; k++) begin
      tick();
      rd(14'h042, 32'(4 - k), "tval_oneshot");
    end
    tick();
    rd(14'h042, 32'hff, "tval_wrap");
    rdm(14'h005, 32'h800, 32'h800, "ti_oneshot");
    tick();
    tick();
    rd(14'h042, 32'hff, "tval_hold");
    chk("has_int_oneshot", 32'h1, {31'b0, has_int});

    // reset mid-count
    wr(14'h041, 32'hffff_ffff, 32'h0b);
    tick();
    tick();
    rd(14'h042, 32'h6, "tval_before_reset");
    reset = 1'b0;
    #1;
    rd(14'h042, 32'hff, "tval_in_reset");
    rd(14'h041, 32'h0, "tcfg_in_reset");
    rd(14'h031, 32'h0, "save1_in_reset");
    chk("has_int_in_reset", 32'h0, {31'b0, has_int});
    reset = 1'b1;
    repeat (3) tick();
    rd(14'h042, 32'hff, "tval_after_reset");
    rd(14'h000, 32'h8, "crmd_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
